// File: rtl/serial_word_receiver.sv
// ============================================================================
// Module      : serial_word_receiver
// Description : Serial-to-parallel receiver; assembles MSB-first WIDTH-bit
//               frames into a one-entry valid/ready output buffer.
//               Optional even-parity bit per frame: `define SERIAL_RX_PARITY_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_word_receiver #(
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Ser_In,
    input  logic             ser_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] Par_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1
`ifdef SERIAL_RX_PARITY_EN
        ,
        S_PAR  = 2'd2
`endif
    } state_t;

    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [CNT_W-1:0] c_full     = CNT_W'(WIDTH);
`endif

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   w_sreg_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_complete;
    logic [WIDTH-1:0]   w_word;
    logic [WIDTH-1:0]   r_par_out;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_overrun;
    logic               w_load;

    assign w_shifted = {r_sreg[WIDTH-2:0], Ser_In};

`ifdef SERIAL_RX_PARITY_EN
    logic               w_perr;
    logic               r_parity_err;
`endif

    // Next-state / datapath decode; frame_start always restarts a frame.
    always_comb begin
        w_next_state = r_state;
        w_sreg_nxt   = r_sreg;
        w_cnt_nxt    = r_bit_cnt;
        w_complete   = 1'b0;
        w_word       = r_sreg;
`ifdef SERIAL_RX_PARITY_EN
        w_perr       = 1'b0;
`endif
        if (ser_valid) begin
            if (frame_start) begin
                w_sreg_nxt   = {{(WIDTH-1){1'b0}}, Ser_In};
                w_cnt_nxt    = c_one;
                w_next_state = S_DATA;
            end else begin
                case (r_state)
                    S_DATA: begin
                        w_sreg_nxt = w_shifted;
                        if (r_bit_cnt == c_last_bit) begin
`ifdef SERIAL_RX_PARITY_EN
                            w_cnt_nxt    = c_full;
                            w_next_state = S_PAR;
`else
                            w_complete   = 1'b1;
                            w_word       = w_shifted;
                            w_cnt_nxt    = '0;
                            w_next_state = S_IDLE;
`endif
                        end else begin
                            w_cnt_nxt = r_bit_cnt + c_one;
                        end
                    end
`ifdef SERIAL_RX_PARITY_EN
                    S_PAR: begin
                        // Data stays parked in sreg while the parity bit arrives.
                        w_complete   = 1'b1;
                        w_word       = r_sreg;
                        w_perr       = (^r_sreg) ^ Ser_In;
                        w_cnt_nxt    = '0;
                        w_next_state = S_IDLE;
                    end
`endif
                    default: begin
                        w_next_state = r_state;
                    end
                endcase
            end
        end
    end

    // A completing word may enter the buffer if it is empty or draining now.
    assign w_load = w_complete && (!r_out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_bit_cnt   <= '0;
            r_par_out   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_sreg    <= w_sreg_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_busy    <= (w_next_state != S_IDLE);
            r_overrun <= w_complete && r_out_valid && !out_ready;
            if (w_load) begin
                r_par_out   <= w_word;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_parity_err <= 1'b0;
        end else if (w_load) begin
            r_parity_err <= w_perr;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign Par_out   = r_par_out;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: 24-bit and 80-bit instances,
// expected words queued at stimulus time and popped at delivery.
`default_nettype none

module tb_serial_word_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        ser_in24 = 1'b0, sv24 = 1'b0, fs24 = 1'b0, ready24 = 1'b1;
    logic [23:0] par24;
    logic        ov24_valid, busy24, ovr24, perr24;

    logic        ser_in80 = 1'b0, sv80 = 1'b0, fs80 = 1'b0, ready80 = 1'b1;
    logic [79:0] par80;
    logic        ov80_valid, busy80, ovr80, perr80;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(24)) dut24 (
        .clk(clk), .rst(rst), .Ser_In(ser_in24), .ser_valid(sv24),
        .frame_start(fs24), .Par_out(par24), .out_valid(ov24_valid),
        .out_ready(ready24), .busy(busy24), .overrun(ovr24), .parity_err(perr24)
    );

    serial_word_receiver #(.WIDTH(80)) dut80 (
        .clk(clk), .rst(rst), .Ser_In(ser_in80), .ser_valid(sv80),
        .frame_start(fs80), .Par_out(par80), .out_valid(ov80_valid),
        .out_ready(ready80), .busy(busy80), .overrun(ovr80), .parity_err(perr80)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need finish)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send24_bit(input logic b, input logic fs);
        ser_in24 = b; sv24 = 1'b1; fs24 = fs;
        tick();
        sv24 = 1'b0; fs24 = 1'b0;
    endtask

    // Full frame, plus a correct even-parity bit when parity is built in.
    task automatic send24_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send24_bit(w[i], i == 23);
`ifdef SERIAL_RX_PARITY_EN
        send24_bit(^w, 1'b0);
`endif
    endtask

    task automatic test_reset();
        logic [27:0] got24;
        logic [83:0] got80;
        rst = 1'b0;
        tick();
        got24 = {ov24_valid, busy24, ovr24, perr24, par24};
        got80 = {ov80_valid, busy80, ovr80, perr80, par80};
        n_tests++;
        if (got24 !== 28'h0) begin
            n_fail++;
            $display("FAIL reset24: got %h need 0", got24);
        end
        n_tests++;
        if (got80 !== 84'h0) begin
            n_fail++;
            $display("FAIL reset80: got %h need 0", got80);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [127:0] exp;
        ready24 = 1'b1;
        exp_q.push_back(128'(24'hA5A5A5));
        send24_word(24'hA5A5A5);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (ov24_valid !== 1'b1 || {104'b0, par24} !== exp || perr24 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_word: got v=%b %h perr=%b need v=1 %h perr=0",
                     ov24_valid, par24, perr24, exp[23:0]);
        end
        tick();
        n_tests++;
        if (ov24_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_one_cycle: got out_valid=%b need 0", ov24_valid);
        end
    endtask

    task automatic test_gaps80();
        logic [79:0]  w = 80'h123456789ABCDEF01234;
        logic [127:0] exp;
        int           bad_busy = 0;
        ready80 = 1'b1;
        exp_q.push_back(128'(w));
        for (int i = 79; i >= 0; i--) begin
            int gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                sv80 = 1'b0;
                tick();
                if (i != 79 && busy80 !== 1'b1) bad_busy++;
            end
            ser_in80 = w[i]; sv80 = 1'b1; fs80 = (i == 79);
            tick();
            sv80 = 1'b0; fs80 = 1'b0;
        end
`ifdef SERIAL_RX_PARITY_EN
        sv80 = 1'b0;
        tick();
        if (busy80 !== 1'b1) bad_busy++;
        ser_in80 = ^w; sv80 = 1'b1;
        tick();
        sv80 = 1'b0;
`endif
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (ov80_valid !== 1'b1 || {48'b0, par80} !== exp || perr80 !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps80_word: got v=%b %h perr=%b need v=1 %h perr=0",
                     ov80_valid, par80, perr80, exp[79:0]);
        end
        n_tests++;
        if (bad_busy !== 0) begin
            n_fail++;
            $display("FAIL gaps80_busy: got %0d idle cycles with busy=0 need 0", bad_busy);
        end
        tick();
        n_tests++;
        if (ov80_valid !== 1'b0 || busy80 !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps80_after: got v=%b busy=%b need 0 0", ov80_valid, busy80);
        end
    endtask

    task automatic test_overrun();
        logic [127:0] exp;
        int           ov_cnt = 0;
        ready24 = 1'b0;
        exp_q.push_back(128'(24'h000001));
        send24_word(24'h000001);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (ov24_valid !== 1'b1 || {104'b0, par24} !== exp) begin
            n_fail++;
            $display("FAIL ovr_first: got v=%b %h need v=1 %h", ov24_valid, par24, exp[23:0]);
        end
        // Buffer full and not draining: the second word must be dropped.
        for (int i = 23; i >= 0; i--) begin
            send24_bit(1'b1, i == 23);
            if (ovr24 === 1'b1) ov_cnt++;
        end
`ifdef SERIAL_RX_PARITY_EN
        send24_bit(1'b0, 1'b0);
        if (ovr24 === 1'b1) ov_cnt++;
`endif
        n_tests++;
        if (ovr24 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_pulse_edge: got overrun=%b need 1", ovr24);
        end
        tick();
        if (ovr24 === 1'b1) ov_cnt++;
        n_tests++;
        if (ov_cnt !== 1) begin
            n_fail++;
            $display("FAIL ovr_pulse_count: got %0d need 1", ov_cnt);
        end
        n_tests++;
        if (ov24_valid !== 1'b1 || par24 !== exp[23:0]) begin
            n_fail++;
            $display("FAIL ovr_kept: got v=%b %h need v=1 %h", ov24_valid, par24, exp[23:0]);
        end
        ready24 = 1'b1;
        tick();
        n_tests++;
        if (ov24_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_accept: got out_valid=%b need 0", ov24_valid);
        end
    endtask

    task automatic test_restart();
        logic [9:0]   junk = 10'h2AB;
        logic [127:0] exp;
        int           ov_cnt = 0;
        ready24 = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            send24_bit(junk[i], i == 9);
            if (ovr24 === 1'b1 || ov24_valid === 1'b1) ov_cnt++;
        end
        exp_q.push_back(128'(24'hC3C3C3));
        send24_word(24'hC3C3C3);
        if (ovr24 === 1'b1) ov_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (ov24_valid !== 1'b1 || {104'b0, par24} !== exp) begin
            n_fail++;
            $display("FAIL restart_word: got v=%b %h need v=1 %h", ov24_valid, par24, exp[23:0]);
        end
        tick();
        n_tests++;
        if (ov_cnt !== 0 || ov24_valid !== 1'b0 || ovr24 !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_extra: got events=%0d v=%b ovr=%b need 0 0 0",
                     ov_cnt, ov24_valid, ovr24);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] exp;
        ready24 = 1'b1;
        for (int i = 0; i < 12; i++) send24_bit(i[0], i == 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_tests++;
        if ({ov24_valid, busy24, ovr24, perr24, par24} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h need 0", {ov24_valid, busy24, ovr24, perr24, par24});
        end
        exp_q.push_back(128'(24'h5A5A5A));
        send24_word(24'h5A5A5A);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (ov24_valid !== 1'b1 || {104'b0, par24} !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_word: got v=%b %h need v=1 %h", ov24_valid, par24, exp[23:0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp;
        ready24 = 1'b1;
        exp_q.push_back(128'(24'h123456));
        exp_q.push_back(128'(24'hFEDCBA));
        send24_word(24'h123456);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (ov24_valid !== 1'b1 || {104'b0, par24} !== exp) begin
            n_fail++;
            $display("FAIL b2b_first: got v=%b %h need v=1 %h", ov24_valid, par24, exp[23:0]);
        end
        send24_word(24'hFEDCBA);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (ov24_valid !== 1'b1 || {104'b0, par24} !== exp || ovr24 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got v=%b %h ovr=%b need v=1 %h ovr=0",
                     ov24_valid, par24, ovr24, exp[23:0]);
        end
        tick();
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        logic [23:0] w = 24'hA5A5A5;
        for (int p = 0; p < 2; p++) begin
            logic exp_err = (^w) ^ p[0];
            for (int i = 23; i >= 0; i--) send24_bit(w[i], i == 23);
            send24_bit(p[0], 1'b0);
            n_tests++;
            if (ov24_valid !== 1'b1 || par24 !== w || perr24 !== exp_err) begin
                n_fail++;
                $display("FAIL parity_%0d: got v=%b %h perr=%b need v=1 %h perr=%b",
                         p, ov24_valid, par24, perr24, w, exp_err);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_gaps80();
        test_overrun();
        test_restart();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending need 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-to-parallel receiver: the receive end of the team's serial word link, paired with the 24/80-bit parallel-load shift registers that drive words out through `Ser_Out`. It samples qualified serial bits, assembles MSB-first frames of `WIDTH` bits and presents each complete word on a one-entry valid/ready output buffer. Shifting continues while a word waits in the buffer. It sits between the serial line and the word consumer (FIFO or datapath).

## Interface
- `WIDTH`, 24: data bits per frame; legal range 2..128, typically 24 or 80.
- `CNT_W`, `$clog2(WIDTH+1)`: bit-counter width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset: one clock, reset is synchronous and active-low.
- `Ser_In`  in  1  serial data bit, sampled only when `ser_valid`=1.
- `ser_valid`  in  1  `Ser_In` holds a valid bit this cycle.
- `frame_start`  in  1  marks the first data bit of a frame; qualified by `ser_valid`.
- `Par_out`  out  WIDTH  received word, first received bit in `Par_out[WIDTH-1]`.
- `out_valid`  out  1  `Par_out` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts the word when `out_valid`=1.
- `busy`  out  1  frame in progress (state not IDLE).
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `parity_err`  out  1  sideband for `Par_out`; valid while `out_valid`=1.

## Operation
- FSM states: IDLE, DATA, and PAR (PAR exists only with the parity option).
- IDLE: `ser_valid`=1 and `frame_start`=1 -> shift in the bit, set `bit_cnt`=1, go to DATA. Valid bits without `frame_start` are ignored.
- DATA: each `ser_valid` shifts `sreg <= {sreg[WIDTH-2:0], Ser_In}` and increments `bit_cnt`. Cycles with `ser_valid`=0 hold all state; gaps are unbounded.
- DATA, bit `bit_cnt`=WIDTH-1 accepted (the WIDTH-th bit) -> word complete. Without parity, deliver and go to IDLE. With parity, latch data and go to PAR.
- PAR: next valid bit is the parity bit. Deliver the word, set `parity_err` = XOR(data, parity bit) (even parity), go to IDLE.
- Delivery loads `{sreg[WIDTH-2:0], Ser_In}` (or the latched data) straight into the output buffer; no extra cycle.
- `frame_start`=1 with `ser_valid`=1 in DATA/PAR: discard the partial frame, restart with this bit as bit 1, no flag.
- Output buffer rules:
  - Handshake completes when `out_valid`=1 and `out_ready`=1 at a clock edge.
  - Completion with buffer empty, or with the buffer handshaking on the same edge: load the buffer; `out_valid` is 1 next cycle.
  - Completion with buffer full and `out_ready`=0: keep the old word, drop the new one, `overrun`=1 for one cycle.
  - Handshake with no completion on that edge: `out_valid` goes to 0.
- `Par_out` and `parity_err` are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset (`rst`=0 at an edge) puts the FSM in IDLE and clears `bit_cnt`, `sreg`, `Par_out`, `out_valid`, `busy`, `overrun` and `parity_err` to 0.
- Reset mid-frame or with the buffer full drops everything held.
- Latency: the last bit (data or parity) is sampled at edge N; `Par_out`/`out_valid` update at edge N and are visible in cycle N+1.
- Throughput: one bit per cycle sustained; back-to-back frames need no idle cycle. `frame_start` may coincide with the cycle after completion.
- `busy`, `overrun` and `parity_err` are registered; there are no combinational input-to-output paths.

## Configuration
- `SERIAL_RX_PARITY_EN` defined: a frame is WIDTH+1 valid bits, PAR state is present, and `parity_err` reports even-parity failure.
- Not defined: a frame is WIDTH bits, there is no PAR state, and `parity_err` is tied to 0.

## Test plan
- WIDTH=24, send 24'hA5A5A5 MSB-first with `ser_valid` high continuously, `out_ready`=1 -> `Par_out`=24'hA5A5A5, `out_valid`=1 for exactly one cycle after the 24th bit edge.
- WIDTH=80, send 80'h123456789ABCDEF01234 with random `ser_valid` gaps -> same word delivered; `busy` stays 1 through the gaps.
- `out_ready`=0, send two 24-bit frames (24'h000001 then 24'hFFFFFF) -> `Par_out` stays 24'h000001, `overrun` pulses once at the second completion. Then raise `out_ready` -> word accepted, `out_valid`=0.
- Send 10 bits, then `frame_start` with 24'hC3C3C3 -> only 24'hC3C3C3 delivered, no `overrun`.
- Send 12 bits, pulse `rst`=0 for one cycle, then send a full 24'h5A5A5A -> all outputs 0 after reset, then 24'h5A5A5A delivered.
- With `SERIAL_RX_PARITY_EN`: 24'hA5A5A5 with parity bit 0 -> `parity_err`=0; with parity bit 1 -> `parity_err`=1 alongside the word.
